// File: rtl/tone_freq_pkg.sv
// Shared types and decode constants for the tone frequency detector.
// The decoder reverses the tone generator's period = code * 2^STEP_SHIFT + TONE_BASE.
package tone_freq_pkg;

  typedef enum logic [1:0] {SYNC, MEAS, DECODE} state_t;
  typedef enum logic [1:0] {UNK, NEG, POS} pol_t;

  localparam int CODE_W     = 4;
  localparam int SUM_W      = 23;
  localparam int TONE_BASE  = 6002;
  localparam int STEP_SHIFT = 16;
  localparam int ROUND_OFS  = (1 << (STEP_SHIFT - 1)) - TONE_BASE;  // 26766

  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  // Average of four periods, rounded to the nearest code step, clamped to the top code.
  function automatic logic [CODE_W-1:0] decode_period(input logic [SUM_W-1:0] sum,
                                                     input int ofs, input int shift);
    logic [SUM_W:0] acc;
    acc = ({1'b0, sum} >> 2) + (SUM_W + 1)'(ofs);
    acc = acc >> shift;
    return (acc > (SUM_W + 1)'(CODE_MAX)) ? CODE_MAX : acc[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/zero_cross_detector.sv
// Hysteresis polarity tracker: flags a rising crossing when a sample above +THRESH
// follows a remembered negative polarity.
module zero_cross_detector
  import tone_freq_pkg::*;
#(
  parameter logic signed [31:0] THRESH = 32'sd1000000
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               sample_valid,
  input  logic signed [31:0] sample,
  input  logic               clear_pol,
  output logic               rise
);

  localparam logic signed [31:0] NEG_THRESH = -THRESH;

  pol_t pol, pol_next;
  logic above, below;

  assign above = sample > THRESH;
  assign below = sample < NEG_THRESH;
  assign rise  = sample_valid && above && (pol == NEG);

  // NOTE: assign every always_comb output a default first, so no path leaves it
  // unassigned and a latch is never inferred.
  always_comb begin
    pol_next = pol;
    if (sample_valid) begin
      if (above)      pol_next = POS;
      else if (below) pol_next = NEG;
    end
  end

  // NOTE: registers use non-blocking <= so every flop samples pre-edge values,
  // independent of statement order across always_ff blocks.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || clear_pol) pol <= UNK;
    else                      pol <= pol_next;
  end

endmodule

// File: rtl/tone_freq_detector.sv
// Measures the period of a received square-wave tone over 4-period windows and
// publishes the 4-bit code once two consecutive windows agree.
module tone_freq_detector
  import tone_freq_pkg::*;
#(
  parameter logic signed [31:0] THRESH     = 32'sd1000000,
  parameter int                 MIN_PERIOD = 4096,
  parameter int                 TIMEOUT    = 2097152,
  parameter int                 DEC_SHIFT  = tone_freq_pkg::STEP_SHIFT,
  parameter int                 DEC_OFS    = tone_freq_pkg::ROUND_OFS
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               audio_in_available,
  input  logic signed [31:0] left_channel_audio_in,
  output logic               read_audio_in,
  output logic [CODE_W-1:0]  frequency,
  output logic               freq_valid,
  output logic               silent
);

  // Wide enough to hold TIMEOUT itself so the saturated value is distinct.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   sum;
  logic [1:0]         k;
  logic [CODE_W-1:0]  cand, est;
  logic               cand_ok;
  logic               rise, timeout_hit, cnt_clr, acc_en;

  assign read_audio_in = audio_in_available & resetn;

  zero_cross_detector #(.THRESH(THRESH)) u_zc (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .sample_valid (read_audio_in),
    .sample       (left_channel_audio_in),
    .clear_pol    (timeout_hit),
    .rise         (rise)
  );

  // Fires only on the cycle cnt steps onto TIMEOUT, so a saturated counter
  // does not keep re-arming the silence reset.
  assign timeout_hit = (cnt == TO_M1);
  assign est         = decode_period(sum, DEC_OFS, DEC_SHIFT);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= SYNC;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    acc_en     = 1'b0;
    if (timeout_hit) begin
      state_next = SYNC;
    end else begin
      case (state)
        SYNC: if (rise) begin
          cnt_clr    = 1'b1;
          state_next = MEAS;
        end
        MEAS: if (rise && cnt >= MIN_C) begin
          acc_en  = 1'b1;
          cnt_clr = 1'b1;
          if (k == 2'd3) state_next = DECODE;
        end
        DECODE: begin
          cnt_clr    = rise;
          state_next = MEAS;
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt        <= '0;
      sum        <= '0;
      k          <= '0;
      cand       <= '0;
      cand_ok    <= 1'b0;
      frequency  <= '0;
      freq_valid <= 1'b0;
      silent     <= 1'b1;
    end else begin
      freq_valid <= 1'b0;
      if (cnt_clr)         cnt <= '0;
      else if (cnt != TO_C) cnt <= cnt + 1'b1;

      if (timeout_hit) begin
        silent    <= 1'b1;
        frequency <= '0;
        sum       <= '0;
        k         <= '0;
        cand_ok   <= 1'b0;
      end else begin
        if (acc_en) begin
          sum <= sum + SUM_W'(cnt);
          k   <= k + 2'd1;
        end
        if (state == DECODE) begin
          if (cand_ok && est == cand) begin
            frequency  <= est;
            freq_valid <= 1'b1;
            silent     <= 1'b0;
          end
          cand    <= est;
          cand_ok <= 1'b1;
          sum     <= '0;
        end
      end
    end
  end

endmodule
